// File: rtl/ice_sl_arbiter.sv
// Round-robin arbiter for the slave bus: one-hot registered grant, frame-end
// release via sl_latch_tail, and forced revocation with requester masking on timeout.
module ice_sl_arbiter #(
   parameter int NUM_DEV = 7,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_DEV-1:0] sl_arb_request,
   input  logic               sl_latch_tail,
   output logic [NUM_DEV-1:0] sl_arb_grant,
   output logic [3:0]         grant_id,
   output logic               grant_valid,
   output logic               timeout_evt,
   output logic [15:0]        frame_count
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   state_t             r_state;
   logic [NUM_DEV-1:0] r_grant;
   logic [NUM_DEV-1:0] r_mask;
   logic [3:0]         r_ptr;
   logic [CW-1:0]      r_cnt;
   logic               r_timeout_evt;
   logic [15:0]        r_frame_count;

   logic [NUM_DEV-1:0] w_eligible;
   logic               w_lowFound;
   logic [3:0]         w_lowPick;
   logic               w_hiFound;
   logic [3:0]         w_hiPick;
   logic [3:0]         w_sel;
   logic               w_ownerReq;
   logic               w_atLimit;
   logic               w_timeout;
   logic [3:0]         w_grantId;

   assign w_eligible = sl_arb_request & ~r_mask;

   // Round robin: lowest eligible index above the pointer wins, otherwise wrap to the lowest overall.
   always_comb begin
      w_lowFound = 1'b0;
      w_lowPick  = 4'd0;
      w_hiFound  = 1'b0;
      w_hiPick   = 4'd0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_lowFound = 1'b1;
            w_lowPick  = 4'(i);
         end
         if (w_eligible[i] && (4'(i) > r_ptr)) begin
            w_hiFound = 1'b1;
            w_hiPick  = 4'(i);
         end
      end
      w_sel = w_hiFound ? w_hiPick : w_lowPick;
   end

   assign w_ownerReq = |(sl_arb_request & r_grant);
   assign w_atLimit  = (r_cnt == CW'(TIMEOUT - 1));
   assign w_timeout  = (r_state == GRANT) && w_ownerReq && !sl_latch_tail && w_atLimit;

   always_comb begin
      w_grantId = 4'd0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (r_grant[i]) begin
            w_grantId = 4'(i);
         end
      end
   end

   // A frame-end pulse coinciding with the limit counts as a normal end, so it never masks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_mask        <= '0;
         r_ptr         <= 4'(NUM_DEV - 1);
         r_cnt         <= '0;
         r_timeout_evt <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         r_timeout_evt <= 1'b0;
         r_mask        <= r_mask & sl_arb_request;
         case (r_state)
            IDLE: begin
               if (w_lowFound) begin
                  r_state <= GRANT;
                  r_grant <= NUM_DEV'(1) << w_sel;
                  r_ptr   <= w_sel;
                  r_cnt   <= '0;
               end
            end
            GRANT: begin
               if (!w_ownerReq || sl_latch_tail || w_atLimit) begin
                  r_state <= GAP;
                  r_grant <= '0;
                  r_cnt   <= '0;
                  if (sl_latch_tail) begin
                     r_frame_count <= r_frame_count + 16'd1;
                  end
                  if (w_timeout) begin
                     r_timeout_evt <= 1'b1;
                     r_mask        <= (r_mask & sl_arb_request) | r_grant;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

   assign sl_arb_grant = r_grant;
   assign grant_id     = w_grantId;
   assign grant_valid  = |r_grant;
   assign timeout_evt  = r_timeout_evt;
   assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_ice_sl_arbiter.sv
// Randomized and directed bench for ice_sl_arbiter, checked cycle by cycle
// against a transaction-level model of owner / gap / round-robin behaviour.
module tb_ice_sl_arbiter;

   localparam int N  = 7;
   localparam int TO = 4096;

   logic         clk;
   logic         reset;
   logic [N-1:0] sl_arb_request;
   logic         sl_latch_tail;
   logic [N-1:0] sl_arb_grant;
   logic [3:0]   grant_id;
   logic         grant_valid;
   logic         timeout_evt;
   logic [15:0]  frame_count;
   logic [28:0]  actVec;

   int total = 0;
   int bad   = 0;

   // Model state: who owns the bus, how long, who was last served, who is masked.
   int          mOwner;
   int          mLast;
   int          mHeld;
   bit          mGap;
   bit [N-1:0]  mMask;
   bit          mTo;
   logic [15:0] mFrames;

   ice_sl_arbiter #(.NUM_DEV(N), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .reset          (reset),
      .sl_arb_request (sl_arb_request),
      .sl_latch_tail  (sl_latch_tail),
      .sl_arb_grant   (sl_arb_grant),
      .grant_id       (grant_id),
      .grant_valid    (grant_valid),
      .timeout_evt    (timeout_evt),
      .frame_count    (frame_count)
   );

   assign actVec = {sl_arb_grant, grant_id, grant_valid, timeout_evt, frame_count};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void modelReset();
      mOwner  = -1;
      mLast   = N - 1;
      mHeld   = 0;
      mGap    = 1'b0;
      mMask   = '0;
      mTo     = 1'b0;
      mFrames = 16'd0;
   endfunction

   // One clock edge of the arbitration rules, applied to the sampled inputs.
   function automatic void modelStep(input logic [N-1:0] req, input logic tail);
      bit [N-1:0] oldMask;
      bit [N-1:0] oh;
      oldMask = mMask;
      mTo     = 1'b0;
      mMask   = mMask & req;
      if (mOwner >= 0) begin
         oh    = N'(1) << mOwner;
         mHeld = mHeld + 1;
         if (tail) begin
            mFrames = mFrames + 16'd1;
            mOwner  = -1;
            mGap    = 1'b1;
         end else if ((req & oh) == 0) begin
            mOwner = -1;
            mGap   = 1'b1;
         end else if (mHeld == TO) begin
            mTo    = 1'b1;
            mMask  = mMask | oh;
            mOwner = -1;
            mGap   = 1'b1;
         end
      end else if (mGap) begin
         mGap = 1'b0;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i  = (mLast + k) % N;
            oh = N'(1) << i;
            if ((req & oh) != 0 && (oldMask & oh) == 0) begin
               mOwner = i;
               mLast  = i;
               mHeld  = 0;
               break;
            end
         end
      end
   endfunction

   function automatic logic [28:0] expVec();
      logic [N-1:0] g;
      logic [3:0]   id;
      g  = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
      id = (mOwner >= 0) ? 4'(mOwner) : 4'd0;
      return {g, id, (mOwner >= 0), mTo, mFrames};
   endfunction

   task automatic cycle(input logic [N-1:0] req, input logic tail);
      sl_arb_request = req;
      sl_latch_tail  = tail;
      @(posedge clk);
      modelStep(req, tail);
      #1;
   endtask

   task automatic applyReset();
      reset          = 1'b0;
      sl_arb_request = '0;
      sl_latch_tail  = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      sl_arb_request = 7'b1111111;
      sl_latch_tail  = 1'b1;
      reset          = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (actVec !== 29'd0) begin
         bad++;
         $display("[TB] FAIL reset_state: got %h want %h", actVec, 29'd0);
      end
      applyReset();
   endtask

   task automatic test_basic();
      applyReset();
      cycle(7'b0000101, 1'b0);
      total++;
      if (sl_arb_grant !== 7'b0000001 || grant_id !== 4'd0) begin
         bad++;
         $display("[TB] FAIL basic_first: got grant %b id %0d want 0000001 id 0", sl_arb_grant, grant_id);
      end
      for (int c = 0; c < 6; c++) begin
         cycle((c < 2) ? 7'b0000101 : 7'b0000100, 1'b0);
         total++;
         if (actVec !== expVec()) begin
            bad++;
            $display("[TB] FAIL basic_cyc%0d: got %h want %h", c, actVec, expVec());
         end
      end
      total++;
      if (sl_arb_grant !== 7'b0000100 || grant_id !== 4'd2 || grant_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_second: got grant %b id %0d want 0000100 id 2", sl_arb_grant, grant_id);
      end
   endtask

   task automatic test_round_robin();
      int order [8];
      int wait_c;
      applyReset();
      for (int f = 0; f < 8; f++) begin
         wait_c = 0;
         while (grant_valid !== 1'b1 && wait_c < 10) begin
            cycle(7'b1111111, 1'b0);
            wait_c++;
            total++;
            if (actVec !== expVec()) begin
               bad++;
               $display("[TB] FAIL rr_wait: got %h want %h", actVec, expVec());
            end
         end
         order[f] = int'(grant_id);
         for (int c = 0; c < 3; c++) begin
            cycle(7'b1111111, (c == 2));
            total++;
            if (actVec !== expVec()) begin
               bad++;
               $display("[TB] FAIL rr_frame%0d: got %h want %h", f, actVec, expVec());
            end
         end
      end
      for (int f = 0; f < 8; f++) begin
         total++;
         if (order[f] != (f % N)) begin
            bad++;
            $display("[TB] FAIL rr_order%0d: got %0d want %0d", f, order[f], f % N);
         end
      end
      total++;
      if (frame_count !== 16'd8) begin
         bad++;
         $display("[TB] FAIL rr_frames: got %0d want 8", frame_count);
      end
   endtask

   task automatic test_timeout();
      int granted = 0;
      int pulses  = 0;
      applyReset();
      for (int c = 0; c < TO + 100; c++) begin
         cycle(7'b0001000, 1'b0);
         if (sl_arb_grant === 7'b0001000) granted++;
         if (timeout_evt === 1'b1) pulses++;
         total++;
         if (actVec !== expVec()) begin
            bad++;
            $display("[TB] FAIL timeout_cyc%0d: got %h want %h", c, actVec, expVec());
         end
      end
      total++;
      if (granted != TO || pulses != 1) begin
         bad++;
         $display("[TB] FAIL timeout_len: got %0d cycles %0d pulses want %0d cycles 1 pulse", granted, pulses, TO);
      end
      cycle(7'b0000000, 1'b0);
      cycle(7'b0001000, 1'b0);
      total++;
      if (sl_arb_grant !== 7'b0001000 || actVec !== expVec()) begin
         bad++;
         $display("[TB] FAIL timeout_regrant: got %b want 0001000", sl_arb_grant);
      end
   endtask

   task automatic test_tail_timeout();
      applyReset();
      cycle(7'b0001000, 1'b0);
      for (int c = 0; c < TO - 1; c++) begin
         cycle(7'b0001000, 1'b0);
      end
      total++;
      if (sl_arb_grant !== 7'b0001000) begin
         bad++;
         $display("[TB] FAIL tailto_held: got %b want 0001000", sl_arb_grant);
      end
      cycle(7'b0001000, 1'b1);
      total++;
      if (timeout_evt !== 1'b0 || frame_count !== 16'd1 || grant_valid !== 1'b0 || actVec !== expVec()) begin
         bad++;
         $display("[TB] FAIL tailto_end: got evt %b count %0d valid %b want 0 1 0", timeout_evt, frame_count, grant_valid);
      end
      cycle(7'b0001000, 1'b0);
      cycle(7'b0001000, 1'b0);
      total++;
      if (sl_arb_grant !== 7'b0001000 || actVec !== expVec()) begin
         bad++;
         $display("[TB] FAIL tailto_unmasked: got %b want 0001000", sl_arb_grant);
      end
   endtask

   task automatic test_wrap();
      applyReset();
      force dut.r_frame_count = 16'hFFFE;
      cycle(7'b0000000, 1'b0);
      release dut.r_frame_count;
      mFrames = 16'hFFFE;
      for (int f = 0; f < 2; f++) begin
         cycle(7'b0000010, 1'b0);
         cycle(7'b0000010, 1'b1);
         total++;
         if (frame_count !== ((f == 0) ? 16'hFFFF : 16'h0000) || actVec !== expVec()) begin
            bad++;
            $display("[TB] FAIL wrap%0d: got %h want %h", f, frame_count, (f == 0) ? 16'hFFFF : 16'h0000);
         end
         cycle(7'b0000000, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      applyReset();
      cycle(7'b0000001, 1'b0);
      cycle(7'b0000001, 1'b0);
      #2 reset = 1'b0;
      modelReset();
      #1;
      total++;
      if (sl_arb_grant !== '0 || grant_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_drop: got %b want 0000000", sl_arb_grant);
      end
      sl_arb_request = 7'b1000000;
      @(posedge clk);
      #1 reset = 1'b1;
      cycle(7'b1000000, 1'b0);
      total++;
      if (sl_arb_grant !== 7'b1000000 || grant_id !== 4'd6 || actVec !== expVec()) begin
         bad++;
         $display("[TB] FAIL midreset_regrant: got %b id %0d want 1000000 id 6", sl_arb_grant, grant_id);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] req;
      logic         tail;
      applyReset();
      req = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(7) == 0) req[b] = ~req[b];
         end
         tail = ($urandom_range(9) == 0);
         cycle(req, tail);
         total++;
         if (actVec !== expVec()) begin
            bad++;
            $display("[TB] FAIL random_cyc%0d: got %h want %h", c, actVec, expVec());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_tail_timeout();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ice_sl_arbiter.md
ICE_SL_ARBITER -- requirements
Module: ice_sl_arbiter

Interface
REQ-001 Parameter NUM_DEV, default 7: number of slave-bus requesters (2..16).
REQ-002 Parameter TIMEOUT, default 4096: maximum grant length in clk cycles (>=4).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
REQ-005 sl_arb_request  input  NUM_DEV  per-requester bus request; bit i = requester i.
REQ-006 sl_latch_tail  input  1  one-cycle pulse from current bus owner marking frame end.
REQ-007 sl_arb_grant  output  NUM_DEV  one-hot grant, registered.
REQ-008 grant_id  output  4  binary index of the granted requester; 0 when idle.
REQ-009 grant_valid  output  1  high while any grant bit is high.
REQ-010 timeout_evt  output  1  one-cycle pulse when a grant is forcibly revoked.
REQ-011 frame_count  output  16  count of grants ended by sl_latch_tail.

Function
REQ-012 States SHALL be IDLE, GRANT, GAP.
REQ-013 sl_arb_grant SHALL have at most one bit set in every cycle.
REQ-014 IDLE: if any unmasked request is high at edge N, SHALL enter GRANT with the grant bit set after edge N (1-cycle latency).
REQ-015 Selection SHALL be round-robin: search starts at (last_granted+1) mod NUM_DEV; pointer after reset = NUM_DEV-1, so requester 0 wins first.
REQ-016 GRANT: grant SHALL hold while owner's request stays high and no end condition occurs.
REQ-017 End conditions in GRANT: owner request low, sl_latch_tail high, or grant cycle counter = TIMEOUT-1; any of these SHALL move to GAP with grant cleared on the same edge.
REQ-018 sl_latch_tail in GRANT SHALL increment frame_count by 1, wrapping 0xFFFF->0x0000; sl_latch_tail outside GRANT SHALL be ignored.
REQ-019 Timeout SHALL pulse timeout_evt for one cycle and set the owner's mask bit; if sl_latch_tail coincides with timeout, it SHALL be treated as a normal end (count increments, no timeout_evt, no mask).
REQ-020 A mask bit SHALL clear when its request is sampled low; masked requesters are not eligible.
REQ-021 GAP SHALL last exactly one cycle with no grant, then return to IDLE; arbitration resumes from IDLE.
REQ-022 Grant cycle counter SHALL clear on entry to GRANT and count clk cycles; width ceil(log2(TIMEOUT)).
REQ-023 Requests changing on non-owners during GRANT SHALL not affect the current grant.
REQ-024 grant_id and grant_valid SHALL be derived from the registered grant, consistent in the same cycle.

Reset
REQ-025 On reset low: state=IDLE, sl_arb_grant=0, grant_id=0, grant_valid=0, timeout_evt=0, frame_count=0, masks=0, RR pointer=NUM_DEV-1, grant counter=0.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant asynchronously; after release, first arbitration follows REQ-014/REQ-015.

Verification
REQ-027 Requests 0b0000101 high from reset release -> grant 0b0000001 one cycle later; owner 0 drops -> grant 0, one GAP cycle, then grant 0b0000100, grant_id=2.
REQ-028 All 7 requests held high, each owner pulses sl_latch_tail after 3 granted cycles -> grant order 0,1,2,3,4,5,6,0; frame_count=8 after eight frames.
REQ-029 Requester 3 alone holds request 4096 cycles -> grant drops after exactly 4096 granted cycles, timeout_evt one pulse, no regrant to 3 until its request goes low then high.
REQ-030 sl_latch_tail and timeout in the same cycle -> timeout_evt stays 0, frame_count +1, requester not masked.
REQ-031 frame_count preloaded by 65535 frames -> next frame end yields 0.
REQ-032 Reset low mid-grant -> sl_arb_grant=0 before next clk edge; after release with requests 0b1000000 -> grant 0b1000000 after one cycle.
